// File: rtl/rvh_pkg.sv
// Shared LSU/L1D widths and the arbitrated L1D request payload.
package rvh_pkg;

    localparam int unsigned LSU_ADDR_PIPE_COUNT = 2;
    localparam int unsigned PADDR_WIDTH         = 40;
    localparam int unsigned XLEN                = 64;
    localparam int unsigned LDQ_TAG_WIDTH       = 4;
    localparam int unsigned STQ_TAG_WIDTH       = 5;
    localparam int unsigned ROB_TAG_WIDTH       = 6;
    localparam int unsigned PTW_ID_WIDTH        = 2;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Wide enough for any of the LDQ index, STQ index or walker id.
    localparam int unsigned LSQ_TAG_WIDTH = max_u(max_u(LDQ_TAG_WIDTH, STQ_TAG_WIDTH), PTW_ID_WIDTH);

    localparam int unsigned L1D_ARB_SRC_W = $clog2(LSU_ADDR_PIPE_COUNT + 2);

    localparam logic [L1D_ARB_SRC_W-1:0] L1D_ARB_SRC_ST  = L1D_ARB_SRC_W'(LSU_ADDR_PIPE_COUNT);
    localparam logic [L1D_ARB_SRC_W-1:0] L1D_ARB_SRC_PTW = L1D_ARB_SRC_W'(LSU_ADDR_PIPE_COUNT + 1);

    typedef struct packed {
        logic [L1D_ARB_SRC_W-1:0] src;
        logic [PADDR_WIDTH-1:0]   paddr;
        logic [XLEN-1:0]          data;
        logic [XLEN/8-1:0]        mask;
        logic [LSQ_TAG_WIDTH-1:0] tag;
        logic [ROB_TAG_WIDTH-1:0] rob_tag;
    } l1d_arb_req_t;

endpackage

// File: rtl/rvh_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rvh_rr_arbiter #(
    parameter int unsigned N = 2,
    localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt
);

    logic             found;
    logic [PTR_W-1:0] idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = PTR_W'((32'(ptr) + i) % N);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rvh_l1d_req_arb.sv
// L1D single-port request arbiter: PTW > boosted store > round-robin loads > store,
// registered into a one-entry valid/ready output stage.
module rvh_l1d_req_arb
    import rvh_pkg::*;
#(
    parameter int unsigned N_LD          = LSU_ADDR_PIPE_COUNT,
    parameter int unsigned STARVE_THRESH = 8,
    parameter int unsigned CNT_W         = $clog2(STARVE_THRESH + 1)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [N_LD-1:0]                      ld_req_vld_i,
    output logic [N_LD-1:0]                      ld_req_rdy_o,
    input  logic [N_LD-1:0][PADDR_WIDTH-1:0]     ld_req_paddr_i,
    input  logic [N_LD-1:0][LDQ_TAG_WIDTH-1:0]   ld_req_lsq_tag_i,
    input  logic [N_LD-1:0][ROB_TAG_WIDTH-1:0]   ld_req_rob_tag_i,
    input  logic                                 st_req_vld_i,
    output logic                                 st_req_rdy_o,
    input  logic [PADDR_WIDTH-1:0]               st_req_paddr_i,
    input  logic [XLEN-1:0]                      st_req_data_i,
    input  logic [XLEN/8-1:0]                    st_req_mask_i,
    input  logic [STQ_TAG_WIDTH-1:0]             st_req_lsq_tag_i,
    input  logic                                 stq_almost_full_i,
    input  logic                                 ptw_req_vld_i,
    output logic                                 ptw_req_rdy_o,
    input  logic [PADDR_WIDTH-1:0]               ptw_req_paddr_i,
    input  logic [PTW_ID_WIDTH-1:0]              ptw_req_id_i,
    input  logic                                 flush_i,
    output logic                                 l1d_req_vld_o,
    input  logic                                 l1d_req_rdy_i,
    output l1d_arb_req_t                         l1d_req_o
);

    localparam int unsigned LD_PTR_W = (N_LD > 1) ? $clog2(N_LD) : 1;

    logic [LD_PTR_W-1:0] rr_ptr;
    logic [CNT_W-1:0]    starve_cnt;

    logic [N_LD-1:0]     ld_req_eff;
    logic [N_LD-1:0]     ld_gnt;
    logic [LD_PTR_W-1:0] ld_idx;
    logic                cap_free;
    logic                boost;
    logic                load_drop;
    logic                ptw_win;
    logic                st_win;
    logic                ld_win;
    logic                any_win;
    l1d_arb_req_t        nxt_req;

    // Loads are invisible during a flush.
    assign ld_req_eff = flush_i ? '0 : ld_req_vld_i;

    rvh_rr_arbiter #(
        .N   (N_LD)
    ) u_ld_arb (
        .req (ld_req_eff),
        .ptr (rr_ptr),
        .gnt (ld_gnt)
    );

    always_comb begin
        ld_idx = '0;
        for (int unsigned k = 0; k < N_LD; k++) begin
            if (ld_gnt[k]) begin
                ld_idx = LD_PTR_W'(k);
            end
        end
    end

    assign cap_free  = !l1d_req_vld_o || l1d_req_rdy_i;
    assign boost     = (starve_cnt == CNT_W'(STARVE_THRESH)) || stq_almost_full_i;
    assign load_drop = flush_i && l1d_req_vld_o && !l1d_req_rdy_i
                       && (l1d_req_o.src < L1D_ARB_SRC_W'(N_LD));

    // Fixed-priority selection among the source classes; nothing granted in reset.
    always_comb begin
        ptw_win = 1'b0;
        st_win  = 1'b0;
        ld_win  = 1'b0;
        if (rst_n && cap_free) begin
            if (ptw_req_vld_i) begin
                ptw_win = 1'b1;
            end else if (st_req_vld_i && boost) begin
                st_win = 1'b1;
            end else if (|ld_req_eff) begin
                ld_win = 1'b1;
            end else if (st_req_vld_i) begin
                st_win = 1'b1;
            end
        end
    end

    assign any_win       = ptw_win || st_win || ld_win;
    assign ld_req_rdy_o  = ld_win ? ld_gnt : '0;
    assign st_req_rdy_o  = st_win;
    assign ptw_req_rdy_o = ptw_win;

    always_comb begin
        nxt_req = '0;
        if (ptw_win) begin
            nxt_req.src   = L1D_ARB_SRC_PTW;
            nxt_req.paddr = ptw_req_paddr_i;
            nxt_req.tag   = LSQ_TAG_WIDTH'(ptw_req_id_i);
        end else if (st_win) begin
            nxt_req.src   = L1D_ARB_SRC_ST;
            nxt_req.paddr = st_req_paddr_i;
            nxt_req.data  = st_req_data_i;
            nxt_req.mask  = st_req_mask_i;
            nxt_req.tag   = LSQ_TAG_WIDTH'(st_req_lsq_tag_i);
        end else begin
            nxt_req.src     = L1D_ARB_SRC_W'(ld_idx);
            nxt_req.paddr   = ld_req_paddr_i[ld_idx];
            nxt_req.tag     = LSQ_TAG_WIDTH'(ld_req_lsq_tag_i[ld_idx]);
            nxt_req.rob_tag = ld_req_rob_tag_i[ld_idx];
        end
    end

    // One-entry output stage; a grant replaces the entry, accept or flush-drop empties it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l1d_req_vld_o <= 1'b0;
            l1d_req_o     <= '0;
        end else if (any_win) begin
            l1d_req_vld_o <= 1'b1;
            l1d_req_o     <= nxt_req;
        end else if (l1d_req_rdy_i || load_drop) begin
            l1d_req_vld_o <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (ld_win) begin
            rr_ptr <= (ld_idx == LD_PTR_W'(N_LD - 1)) ? '0 : ld_idx + LD_PTR_W'(1);
        end
    end

    // Counts consecutive cycles a pending store has lost arbitration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!st_req_vld_i || st_win) begin
            starve_cnt <= '0;
        end else if (starve_cnt != CNT_W'(STARVE_THRESH)) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_rvh_l1d_req_arb.sv
// Randomized scoreboard bench for rvh_l1d_req_arb against a queue-based reference model.
module tb_rvh_l1d_req_arb;
    import rvh_pkg::*;

    localparam int unsigned N_LD   = LSU_ADDR_PIPE_COUNT;
    localparam int          THRESH = 8;

    logic                               clk;
    logic                               rst_n;
    logic [N_LD-1:0]                    ld_req_vld_i;
    logic [N_LD-1:0]                    ld_req_rdy_o;
    logic [N_LD-1:0][PADDR_WIDTH-1:0]   ld_req_paddr_i;
    logic [N_LD-1:0][LDQ_TAG_WIDTH-1:0] ld_req_lsq_tag_i;
    logic [N_LD-1:0][ROB_TAG_WIDTH-1:0] ld_req_rob_tag_i;
    logic                               st_req_vld_i;
    logic                               st_req_rdy_o;
    logic [PADDR_WIDTH-1:0]             st_req_paddr_i;
    logic [XLEN-1:0]                    st_req_data_i;
    logic [XLEN/8-1:0]                  st_req_mask_i;
    logic [STQ_TAG_WIDTH-1:0]           st_req_lsq_tag_i;
    logic                               stq_almost_full_i;
    logic                               ptw_req_vld_i;
    logic                               ptw_req_rdy_o;
    logic [PADDR_WIDTH-1:0]             ptw_req_paddr_i;
    logic [PTW_ID_WIDTH-1:0]            ptw_req_id_i;
    logic                               flush_i;
    logic                               l1d_req_vld_o;
    logic                               l1d_req_rdy_i;
    l1d_arb_req_t                       l1d_req_o;

    int n_cmp = 0;
    int n_err = 0;

    l1d_arb_req_t exp_q[$];
    int           rr     = 0;
    int           starve = 0;

    rvh_l1d_req_arb dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .ld_req_vld_i      (ld_req_vld_i),
        .ld_req_rdy_o      (ld_req_rdy_o),
        .ld_req_paddr_i    (ld_req_paddr_i),
        .ld_req_lsq_tag_i  (ld_req_lsq_tag_i),
        .ld_req_rob_tag_i  (ld_req_rob_tag_i),
        .st_req_vld_i      (st_req_vld_i),
        .st_req_rdy_o      (st_req_rdy_o),
        .st_req_paddr_i    (st_req_paddr_i),
        .st_req_data_i     (st_req_data_i),
        .st_req_mask_i     (st_req_mask_i),
        .st_req_lsq_tag_i  (st_req_lsq_tag_i),
        .stq_almost_full_i (stq_almost_full_i),
        .ptw_req_vld_i     (ptw_req_vld_i),
        .ptw_req_rdy_o     (ptw_req_rdy_o),
        .ptw_req_paddr_i   (ptw_req_paddr_i),
        .ptw_req_id_i      (ptw_req_id_i),
        .flush_i           (flush_i),
        .l1d_req_vld_o     (l1d_req_vld_o),
        .l1d_req_rdy_i     (l1d_req_rdy_i),
        .l1d_req_o         (l1d_req_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Monitor: the DUT output stage must mirror the head of the expected queue.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_vld", 256'(l1d_req_vld_o), 256'(0));
            chk("rst_payload", 256'(l1d_req_o), 256'(0));
            exp_q.delete();
        end else if (exp_q.size() == 0) begin
            chk("idle_vld", 256'(l1d_req_vld_o), 256'(0));
        end else begin
            chk("out_vld", 256'(l1d_req_vld_o), 256'(1));
            chk("out_payload", 256'(l1d_req_o), 256'(exp_q[0]));
            if (l1d_req_rdy_i) void'(exp_q.pop_front());
        end
    end

    task automatic model_step();
        logic [N_LD+1:0] act_rdy;
        logic [N_LD+1:0] exp_rdy;
        l1d_arb_req_t    e;
        bit              cap;
        bit              held_ld;
        int              win;
        int              k;
        act_rdy = {ptw_req_rdy_o, st_req_rdy_o, ld_req_rdy_o};
        if (!rst_n) begin
            chk("rst_rdy", 256'(act_rdy), 256'(0));
            exp_q.delete();
            rr     = 0;
            starve = 0;
            return;
        end
        chk("starve_cnt", 256'(dut.starve_cnt), 256'(starve));
        held_ld = (exp_q.size() != 0) && (int'(exp_q[0].src) < int'(N_LD));
        cap     = (exp_q.size() == 0) || l1d_req_rdy_i;
        win     = -1;
        if (cap) begin
            if (ptw_req_vld_i) win = N_LD + 1;
            else if (st_req_vld_i && (starve >= THRESH || stq_almost_full_i)) win = N_LD;
            else begin
                if (!flush_i) begin
                    for (int i = 0; i < N_LD; i++) begin
                        k = (rr + i) % N_LD;
                        if (win < 0 && ld_req_vld_i[k]) win = k;
                    end
                end
                if (win < 0 && st_req_vld_i) win = N_LD;
            end
        end
        exp_rdy = (win >= 0) ? ((N_LD + 2)'(1) << win) : '0;
        chk("grant", 256'(act_rdy), 256'(exp_rdy));

        if (flush_i && held_ld && !l1d_req_rdy_i) void'(exp_q.pop_front());
        if (!st_req_vld_i || win == N_LD) starve = 0;
        else if (starve < THRESH) starve = starve + 1;
        if (win >= 0 && win < N_LD) rr = (win + 1) % N_LD;

        if (win >= 0) begin
            e = '0;
            e.src = L1D_ARB_SRC_W'(win);
            if (win == N_LD + 1) begin
                e.paddr = ptw_req_paddr_i;
                e.tag   = LSQ_TAG_WIDTH'(ptw_req_id_i);
            end else if (win == N_LD) begin
                e.paddr = st_req_paddr_i;
                e.data  = st_req_data_i;
                e.mask  = st_req_mask_i;
                e.tag   = LSQ_TAG_WIDTH'(st_req_lsq_tag_i);
            end else begin
                e.paddr   = ld_req_paddr_i[win];
                e.tag     = LSQ_TAG_WIDTH'(ld_req_lsq_tag_i[win]);
                e.rob_tag = ld_req_rob_tag_i[win];
            end
            exp_q.push_back(e);
        end
    endtask

    // Reference model steps once per cycle, after the monitor has seen the output stage.
    always @(negedge clk) begin
        #1;
        model_step();
    end

    task automatic step(input logic [N_LD-1:0] lv, input logic sv, input logic pv,
                        input logic af, input logic fl, input logic rdy);
        for (int i = 0; i < N_LD; i++) begin
            ld_req_paddr_i[i]   = PADDR_WIDTH'({$urandom(), $urandom()});
            ld_req_lsq_tag_i[i] = LDQ_TAG_WIDTH'($urandom());
            ld_req_rob_tag_i[i] = ROB_TAG_WIDTH'($urandom());
        end
        st_req_paddr_i    = PADDR_WIDTH'({$urandom(), $urandom()});
        st_req_data_i     = XLEN'({$urandom(), $urandom()});
        st_req_mask_i     = (XLEN/8)'($urandom());
        st_req_lsq_tag_i  = STQ_TAG_WIDTH'($urandom());
        ptw_req_paddr_i   = PADDR_WIDTH'({$urandom(), $urandom()});
        ptw_req_id_i      = PTW_ID_WIDTH'($urandom());
        ld_req_vld_i      = lv;
        st_req_vld_i      = sv;
        ptw_req_vld_i     = pv;
        stq_almost_full_i = af;
        flush_i           = fl;
        l1d_req_rdy_i     = rdy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) step(2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b1;
        repeat (2) step(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // both loads streaming
        repeat (6) step(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        // everybody at once
        step(2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        repeat (2) step(2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (2) step(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        // store starving behind a continuous load
        repeat (12) step(2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        // STQ pressure
        step(2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        step(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        // flush of a stalled load with a store waiting
        step(2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) step(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        repeat (3000) begin
            step(N_LD'($urandom_range(0, (1 << N_LD) - 1)), ($urandom % 4) != 0,
                 ($urandom % 8) == 0, ($urandom % 16) == 0, ($urandom % 10) == 0,
                 ($urandom % 4) != 0);
        end

        // reset while an entry is held
        step(2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        repeat (2) step(2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        repeat (4) step(2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (2) step(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
